// File: rtl/bp_btb_assoc.sv
// Set-associative branch target buffer with per-entry 2-bit direction counters.
// Combinational lookup on the fetch PC, training from execute, and a
// one-set-per-cycle invalidate sweep for fence.i / context switch.
module bp_btb_assoc #(
  parameter int XLEN     = 64,
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 2,
  parameter int TAG_BITS = 32,
  parameter int IDX_LSB  = 2
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_fetch_i,
  input  logic [XLEN-1:0] pc_execution_i,
  input  logic            is_branch_EX_i,
  input  logic            branch_taken_result_exec_i,
  input  logic [XLEN-1:0] branch_addr_result_exec_i,
  output logic            predict_hit_o,
  output logic            predict_taken_o,
  output logic [XLEN-1:0] predict_addr_o,
  output logic            flush_busy_o
);

  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e               state_q;
  logic [IDX_BITS-1:0]  cnt_q;
  logic                 busy_q;

  logic [NUM_WAYS-1:0]  valid_q  [NUM_SETS];
  logic [WAY_BITS-1:0]  rr_q     [NUM_SETS];
  logic [1:0]           ctr_q    [NUM_SETS][NUM_WAYS];
  logic [TAG_BITS-1:0]  tag_q    [NUM_SETS][NUM_WAYS];
  logic [XLEN-1:0]      target_q [NUM_SETS][NUM_WAYS];

  // Saturating update of a 2-bit direction counter.
  function automatic logic [1:0] ctr_sat(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    r = c;
    if (taken && c != 2'b11) r = c + 2'b01;
    else if (!taken && c != 2'b00) r = c - 2'b01;
    return r;
  endfunction

  logic [IDX_BITS-1:0] f_idx, e_idx;
  logic [TAG_BITS-1:0] f_tag, e_tag;
  logic                f_hit, e_hit, e_inv;
  logic [WAY_BITS-1:0] f_way, e_way, e_inv_way, e_victim, rr_next;
  logic                train_en;
  logic                unused_pc_bits;

  assign f_idx = pc_fetch_i[IDX_LSB +: IDX_BITS];
  assign f_tag = pc_fetch_i[IDX_LSB+IDX_BITS +: TAG_BITS];
  assign e_idx = pc_execution_i[IDX_LSB +: IDX_BITS];
  assign e_tag = pc_execution_i[IDX_LSB+IDX_BITS +: TAG_BITS];
  assign unused_pc_bits = ^{pc_fetch_i, pc_execution_i};

  // Fetch lookup: descending scan so the lowest-numbered matching way wins.
  always_comb begin
    f_hit = 1'b0;
    f_way = '0;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (valid_q[f_idx][w] && tag_q[f_idx][w] == f_tag) begin
        f_hit = 1'b1;
        f_way = w[WAY_BITS-1:0];
      end
    end
  end

  // Execute lookup: matching way plus lowest invalid way for allocation.
  always_comb begin
    e_hit     = 1'b0;
    e_way     = '0;
    e_inv     = 1'b0;
    e_inv_way = '0;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (valid_q[e_idx][w] && tag_q[e_idx][w] == e_tag) begin
        e_hit = 1'b1;
        e_way = w[WAY_BITS-1:0];
      end
      if (!valid_q[e_idx][w]) begin
        e_inv     = 1'b1;
        e_inv_way = w[WAY_BITS-1:0];
      end
    end
  end

  assign e_victim = e_inv ? e_inv_way : rr_q[e_idx];
  assign rr_next  = (NUM_WAYS == 1) ? '0 : rr_q[e_idx] + WAY_BITS'(1);
  assign train_en = is_branch_EX_i && (state_q == IDLE);

  assign flush_busy_o    = busy_q;
  assign predict_hit_o   = f_hit && !busy_q;
  assign predict_taken_o = predict_hit_o && ctr_q[f_idx][f_way][1];
  assign predict_addr_o  = predict_hit_o ? target_q[f_idx][f_way] : '0;

  // Control state: FSM, sweep counter, valid bits, counters and replacement pointers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
        for (int w = 0; w < NUM_WAYS; w++) ctr_q[s][w] <= 2'b00;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (train_en) begin
            if (e_hit) begin
              ctr_q[e_idx][e_way] <= ctr_sat(ctr_q[e_idx][e_way], branch_taken_result_exec_i);
            end else begin
              valid_q[e_idx][e_victim] <= 1'b1;
              ctr_q[e_idx][e_victim]   <= branch_taken_result_exec_i ? 2'b10 : 2'b01;
              if (!e_inv) rr_q[e_idx] <= rr_next;
            end
          end
          if (flush_i) begin
            state_q <= FLUSH;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        FLUSH: begin
          valid_q[cnt_q] <= '0;
          rr_q[cnt_q]    <= '0;
          if (flush_i) begin
            cnt_q <= '0;
          end else if (cnt_q == IDX_BITS'(NUM_SETS-1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + IDX_BITS'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and target storage; unreset, only meaningful behind a valid bit.
  always_ff @(posedge clk_i) begin
    if (train_en) begin
      if (e_hit) begin
        target_q[e_idx][e_way] <= branch_addr_result_exec_i;
      end else begin
        tag_q[e_idx][e_victim]    <= e_tag;
        target_q[e_idx][e_victim] <= branch_addr_result_exec_i;
      end
    end
  end

endmodule

// File: tb/tb_bp_btb_assoc.sv
// Directed bench for bp_btb_assoc: table of train/fetch vectors plus
// hand-written flush, re-flush and reset-during-sweep sequences.
module tb_bp_btb_assoc;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        flush_i;
  logic [63:0] pc_fetch_i;
  logic [63:0] pc_execution_i;
  logic        is_branch_EX_i;
  logic        branch_taken_result_exec_i;
  logic [63:0] branch_addr_result_exec_i;
  logic        predict_hit_o;
  logic        predict_taken_o;
  logic [63:0] predict_addr_o;
  logic        flush_busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  bp_btb_assoc dut (
    .clk_i                      (clk_i),
    .rstn_i                     (rstn_i),
    .flush_i                    (flush_i),
    .pc_fetch_i                 (pc_fetch_i),
    .pc_execution_i             (pc_execution_i),
    .is_branch_EX_i             (is_branch_EX_i),
    .branch_taken_result_exec_i (branch_taken_result_exec_i),
    .branch_addr_result_exec_i  (branch_addr_result_exec_i),
    .predict_hit_o              (predict_hit_o),
    .predict_taken_o            (predict_taken_o),
    .predict_addr_o             (predict_addr_o),
    .flush_busy_o               (flush_busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        train;
    logic        taken;
    logic [63:0] tpc;
    logic [63:0] tgt;
    logic [63:0] fpc;
    logic        hit;
    logic        tk;
    logic [63:0] addr;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic tr, input logic tk, input logic [63:0] tpc,
                       input logic [63:0] tgt, input logic [63:0] fpc);
    is_branch_EX_i             = tr;
    branch_taken_result_exec_i = tk;
    pc_execution_i             = tpc;
    branch_addr_result_exec_i  = tgt;
    pc_fetch_i                 = fpc;
  endtask

  task automatic check_lookup(input string name, input logic hit, input logic tk, input logic [63:0] addr);
    #1;
    check({name, ".hit"},   {63'd0, predict_hit_o},   {63'd0, hit});
    check({name, ".taken"}, {63'd0, predict_taken_o}, {63'd0, tk});
    check({name, ".addr"},  predict_addr_o,           addr);
  endtask

  task automatic train_one(input logic [63:0] pc, input logic tk, input logic [63:0] tgt);
    drive(1'b1, tk, pc, tgt, 64'h0);
    step();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
  endtask

  initial begin
    // Set 0 (defaults): 0x1000, 0x1100, 0x1200, 0x1300. Set 1: 0x1004.
    vecs[0]  = '{1'b1, 1'b1, 64'h1000, 64'h2000, 64'h1000, 1'b0, 1'b0, 64'h0};    // same-cycle miss
    vecs[1]  = '{1'b1, 1'b0, 64'h1000, 64'h2000, 64'h1000, 1'b1, 1'b1, 64'h2000}; // ctr 2 -> 1
    vecs[2]  = '{1'b1, 1'b1, 64'h1000, 64'h2000, 64'h1000, 1'b1, 1'b0, 64'h2000}; // ctr 1 -> 2
    vecs[3]  = '{1'b1, 1'b1, 64'h1000, 64'h2000, 64'h1000, 1'b1, 1'b1, 64'h2000}; // 2 -> 3
    vecs[4]  = '{1'b1, 1'b1, 64'h1000, 64'h2000, 64'h1000, 1'b1, 1'b1, 64'h2000}; // 3 -> 3
    vecs[5]  = '{1'b1, 1'b0, 64'h1000, 64'h2000, 64'h1000, 1'b1, 1'b1, 64'h2000}; // 3 -> 2
    vecs[6]  = '{1'b1, 1'b0, 64'h1000, 64'h2000, 64'h1000, 1'b1, 1'b1, 64'h2000}; // 2 -> 1
    vecs[7]  = '{1'b1, 1'b0, 64'h1000, 64'h2000, 64'h1000, 1'b1, 1'b0, 64'h2000}; // 1 -> 0
    vecs[8]  = '{1'b1, 1'b0, 64'h1000, 64'h2000, 64'h1000, 1'b1, 1'b0, 64'h2000}; // 0 -> 0
    vecs[9]  = '{1'b1, 1'b1, 64'h1000, 64'h3000, 64'h1000, 1'b1, 1'b0, 64'h2000}; // 0 -> 1, new target
    vecs[10] = '{1'b0, 1'b0, 64'h0,    64'h0,    64'h1000, 1'b1, 1'b0, 64'h3000};
    vecs[11] = '{1'b1, 1'b1, 64'h1100, 64'h4100, 64'h1100, 1'b0, 1'b0, 64'h0};    // fills way 1
    vecs[12] = '{1'b0, 1'b0, 64'h0,    64'h0,    64'h1100, 1'b1, 1'b1, 64'h4100};
    vecs[13] = '{1'b0, 1'b0, 64'h0,    64'h0,    64'h1000, 1'b1, 1'b0, 64'h3000};
    vecs[14] = '{1'b1, 1'b0, 64'h1200, 64'h4200, 64'h1200, 1'b0, 1'b0, 64'h0};    // evicts way 0
    vecs[15] = '{1'b0, 1'b0, 64'h0,    64'h0,    64'h1000, 1'b0, 1'b0, 64'h0};
    vecs[16] = '{1'b0, 1'b0, 64'h0,    64'h0,    64'h1100, 1'b1, 1'b1, 64'h4100};
    vecs[17] = '{1'b0, 1'b0, 64'h0,    64'h0,    64'h1200, 1'b1, 1'b0, 64'h4200};
    vecs[18] = '{1'b1, 1'b1, 64'h1300, 64'h4300, 64'h1300, 1'b0, 1'b0, 64'h0};    // evicts way 1
    vecs[19] = '{1'b0, 1'b0, 64'h0,    64'h0,    64'h1100, 1'b0, 1'b0, 64'h0};
    vecs[20] = '{1'b0, 1'b0, 64'h0,    64'h0,    64'h1300, 1'b1, 1'b1, 64'h4300};
    vecs[21] = '{1'b0, 1'b0, 64'h0,    64'h0,    64'h1200, 1'b1, 1'b0, 64'h4200};
    vecs[22] = '{1'b1, 1'b1, 64'h1004, 64'h5000, 64'h1004, 1'b0, 1'b0, 64'h0};    // set 1
    vecs[23] = '{1'b0, 1'b0, 64'h0,    64'h0,    64'h1004, 1'b1, 1'b1, 64'h5000};

    rstn_i  = 1'b0;
    flush_i = 1'b0;
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h1000);
    repeat (3) step();
    rstn_i = 1'b1;
    step();

    // Reset state
    check_lookup("reset", 1'b0, 1'b0, 64'h0);
    check("reset.busy", {63'd0, flush_busy_o}, 64'd0);

    // Table-driven train/fetch vectors; expectations are pre-edge values
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].train, vecs[i].taken, vecs[i].tpc, vecs[i].tgt, vecs[i].fpc);
      check_lookup($sformatf("vec%0d", i), vecs[i].hit, vecs[i].tk, vecs[i].addr);
      step();
    end
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h0);

    // Flush sweep: busy for exactly 64 cycles, lookups gated, training dropped
    flush_i = 1'b1;
    #1;
    check("flush.busy_pre", {63'd0, flush_busy_o}, 64'd0);
    step();
    flush_i = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (c == 5) drive(1'b1, 1'b1, 64'h1400, 64'h9000, 64'h1300);
      else        drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h1300);
      #1;
      check($sformatf("flush.busy%0d", c), {63'd0, flush_busy_o}, 64'd1);
      if (c == 0 || c == 5 || c == 63) check_lookup($sformatf("flush.gate%0d", c), 1'b0, 1'b0, 64'h0);
      step();
    end
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    #1;
    check("flush.busy_end", {63'd0, flush_busy_o}, 64'd0);
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h1200); check_lookup("post.1200", 1'b0, 1'b0, 64'h0);
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h1300); check_lookup("post.1300", 1'b0, 1'b0, 64'h0);
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h1004); check_lookup("post.1004", 1'b0, 1'b0, 64'h0);
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h1400); check_lookup("post.1400", 1'b0, 1'b0, 64'h0);
    // Training accepted in the cycle busy drops
    drive(1'b1, 1'b1, 64'h1000, 64'h6000, 64'h1000);
    step();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h1000);
    check_lookup("post.train", 1'b1, 1'b1, 64'h6000);

    // Re-pulse at sweep cycle 30 restarts the 64-cycle sweep
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    for (int c = 0; c < 30; c++) step();
    flush_i = 1'b1;
    #1;
    check("reflush.busy30", {63'd0, flush_busy_o}, 64'd1);
    step();
    flush_i = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      check($sformatf("reflush.busy%0d", c), {63'd0, flush_busy_o}, 64'd1);
      step();
    end
    #1;
    check("reflush.busy_end", {63'd0, flush_busy_o}, 64'd0);

    // Reset at sweep cycle 10; entry in set 40 not yet reached by the sweep
    train_one(64'h10A0, 1'b1, 64'h7000);
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h10A0);
    check_lookup("rst.pre", 1'b1, 1'b1, 64'h7000);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    for (int c = 0; c < 10; c++) step();
    #1;
    check("rst.busy_before", {63'd0, flush_busy_o}, 64'd1);
    rstn_i = 1'b0;
    #1;
    check("rst.busy_async", {63'd0, flush_busy_o}, 64'd0);
    step();
    rstn_i = 1'b1;
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h10A0);
    check_lookup("rst.miss10A0", 1'b0, 1'b0, 64'h0);
    check("rst.busy_after", {63'd0, flush_busy_o}, 64'd0);
    drive(1'b1, 1'b0, 64'h10A0, 64'h7700, 64'h10A0);
    step();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h10A0);
    check_lookup("rst.retrain", 1'b1, 1'b0, 64'h7700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
